// File: rtl/cdb_arbiter_pkg.sv
// Shared RV32I pipeline types: the common data bus result record and FU count.
package rv32i_types;

  localparam int unsigned NUM_FU = 4;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_idx;
    logic [5:0]  pd;
    logic [31:0] data;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin priority picker: first set request at or after ptr, wrapping to 0.
module rr_picker #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_FU-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = (ptr + k) % NUM_FU;
      if (!found && req[idx[IDX_W-1:0]]) begin
        found                  = 1'b1;
        grant[idx[IDX_W-1:0]]  = 1'b1;
        grant_idx              = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin
// broadcast of one held result per cycle.
module cdb_arbiter
  import rv32i_types::cdb_t;
#(
  parameter int unsigned NUM_FU = rv32i_types::NUM_FU,
  parameter int unsigned IDX_W  = $clog2(NUM_FU)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  cdb_t              fu_in [NUM_FU],
  output logic [NUM_FU-1:0] fu_ready,
  output cdb_t              cdb_out,
  output logic [IDX_W-1:0]  grant_idx,
  output logic [31:0]       conflict_cnt
);

  logic [NUM_FU-1:0] held_valid_q, held_valid_d;
  logic [NUM_FU-1:0] grant, capture;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d, pick_idx;
  logic [31:0]       conflict_q, conflict_d;
  logic              any_held;
  cdb_t              held_q [NUM_FU];

  rr_picker #(
    .NUM_FU (NUM_FU),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req       (held_valid_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (pick_idx)
  );

  assign any_held = |held_valid_q;

  // A granted slot drains this edge, so it can accept a new result at once.
  assign fu_ready = rst ? '1 : (~held_valid_q | grant);

  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      capture[i] = fu_in[i].valid && fu_ready[i] && !flush && !rst;
    end
  end

  always_comb begin
    held_valid_d = (held_valid_q & ~grant) | capture;
    rr_ptr_d     = rr_ptr_q;
    conflict_d   = conflict_q;
    if (flush) begin
      held_valid_d = '0;
      rr_ptr_d     = '0;
    end else begin
      if (any_held) begin
        rr_ptr_d = (pick_idx == IDX_W'(NUM_FU - 1)) ? '0 : pick_idx + IDX_W'(1);
      end
      if ($countones(held_valid_q) >= 2) begin
        conflict_d = conflict_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid_q <= '0;
      rr_ptr_q     <= '0;
      conflict_q   <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      conflict_q   <= conflict_d;
    end
  end

  // Payload needs no reset; held_valid_q qualifies it.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (capture[i]) held_q[i] <= fu_in[i];
    end
  end

  always_comb begin
    cdb_out       = held_q[pick_idx];
    cdb_out.valid = any_held && !flush && !rst;
  end

  assign grant_idx    = rst ? '0 : pick_idx;
  assign conflict_cnt = conflict_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NUM_FU, default 4, number of functional-unit result sources; index 0=add, 1=mul, 2=div, 3=br.
REQ-002 Parameter: IDX_W, default 2, width of grant index, equal to clog2(NUM_FU).
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: flush  input  1  pipeline flush; discard all held results.
REQ-006 Port: fu_in  input  NUM_FU x cdb_t  per-FU result; .valid qualifies.
REQ-007 Port: fu_ready  output  NUM_FU  FU may present a new result this cycle.
REQ-008 Port: cdb_out  output  cdb_t  single broadcast result; .valid qualifies.
REQ-009 Port: grant_idx  output  IDX_W  source index of cdb_out; meaningful only when cdb_out.valid.
REQ-010 Port: conflict_cnt  output  32  count of cycles where more than one entry was held.

Function
REQ-011 One holding slot per FU: held_valid[i] and held_data[i] (cdb_t).
REQ-012 Capture: fu_in[i].valid && fu_ready[i] at an edge -> slot i loads fu_in[i], held_valid[i]=1.
REQ-013 Latency: a result presented in cycle N appears on cdb_out in cycle N+1 at the earliest; no combinational path from fu_in to cdb_out.
REQ-014 Arbitration: round-robin over held_valid; search starts at rr_ptr, wrapping NUM_FU-1 -> 0.
REQ-015 Exactly one slot granted per cycle when any held_valid=1; none otherwise.
REQ-016 cdb_out = held_data[grant] with valid=1; when no grant, cdb_out.valid=0 and the other fields are don't-care.
REQ-017 On grant to i: held_valid[i] clears at the edge unless slot i captures a new result at the same edge; rr_ptr <= (i+1) mod NUM_FU.
REQ-018 With no grant, rr_ptr holds.
REQ-019 fu_ready[i] = !held_valid[i] || grant[i], combinational; it gives back-to-back throughput of 1 result/cycle per FU when uncontested.
REQ-020 A valid on fu_in[i] while fu_ready[i]=0 is a protocol violation: the input is ignored and the held slot is unchanged.
REQ-021 Starvation bound: a held entry is broadcast within NUM_FU cycles of capture.
REQ-022 flush: all held_valid clear at the edge and fu_in captures in the same cycle are dropped.
REQ-023 During flush, cdb_out.valid is forced 0 in that cycle and rr_ptr resets to 0.
REQ-024 conflict_cnt increments by 1 each cycle where popcount(held_valid)>=2 and flush=0.
REQ-025 conflict_cnt wraps from 2^32-1 to 0 and is not cleared by flush.

Reset
REQ-026 rst clears all held_valid, rr_ptr=0 and conflict_cnt=0, and takes priority over flush and capture.
REQ-027 Outputs during and after reset: cdb_out.valid=0, grant_idx=0, fu_ready all 1.
REQ-028 Reset asserted mid-operation discards held results without broadcasting them.

Structure
REQ-029 cdb_t and NUM_FU belong in rv32i_types, and this block imports them.
REQ-030 The round-robin priority picker is one sub-module, rr_picker, with ports req[NUM_FU], ptr, grant one-hot and grant_idx.
REQ-031 The block sits between the execute stage outputs (cdb_add/mul/div/br) and the ROB, RS and physical regfile consumers.

Verification
REQ-032 Single source: add valid, rob_idx=5, cycle 0 -> cdb_out valid, rob_idx=5, grant_idx=0 in cycle 1; fu_ready[0] stays 1 throughout.
REQ-033 All four sources valid in cycle 0, rr_ptr=0 -> grants 0,1,2,3 in cycles 1-4; conflict_cnt=3 at the end.
REQ-034 Back-to-back: add valid in cycles 0-3 with mul idle -> cdb_out valid in cycles 1-4 with rob_idx in order.
REQ-035 Hold: add and br held, add granted, br re-presents while fu_ready[3]=0 -> input ignored; br's original data is broadcast next cycle.
REQ-036 Flush with 3 slots held and mul arriving -> cdb_out.valid=0 the next cycle, all fu_ready=1, nothing broadcast afterwards.
REQ-037 rst asserted while 2 slots are held -> the next cycle shows cdb_out.valid=0, conflict_cnt=0, rr_ptr=0.
